i2c_slave_reg_bank: RTL

Register-mapped I2C target built on the slave-side handshake of the I2C byte controller (slave_dat_avail / slave_dat_req / sl_cont). It turns the controller's byte events into a pointer-addressed bank of 8-bit registers:
- A write transaction sets the register pointer, then stores data with auto-increment.
- A read transaction returns register contents with auto-increment.

A local port gives the rest of the SoC concurrent access to the same registers.

---
 rtl/i2c_slave_reg_bank.sv | 124 ++++++++++++
 1 files changed

// File: rtl/i2c_slave_reg_bank.sv
// Pointer-addressed 8-bit register bank behind the I2C byte controller's slave handshake.
// I2C writes set the pointer then store with auto-increment; reads prefetch with auto-increment.
module i2c_slave_reg_bank #(
  parameter int unsigned       NREGS   = 16,
  parameter int unsigned       AW      = $clog2(NREGS),
  parameter logic [NREGS-1:0]  RO_MASK = '0
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          slave_act,
  input  logic          slave_dat_avail,
  input  logic          slave_dat_req,
  input  logic [7:0]    rx_byte,
  output logic [7:0]    tx_byte,
  output logic          sl_cont,
  input  logic          loc_we,
  input  logic [AW-1:0] loc_addr,
  input  logic [7:0]    loc_wdata,
  output logic [7:0]    loc_rdata,
  output logic          i2c_wr_strobe,
  output logic [AW-1:0] i2c_wr_addr,
  output logic [7:0]    i2c_wr_data,
  output logic [AW-1:0] reg_ptr
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PTR, S_DATA, S_CONT} state_t;

  state_t        r_state;
  state_t        r_next;
  logic [7:0]    r_regs [NREGS];
  logic [AW-1:0] r_ptr;
  logic [7:0]    r_tx;
  logic          r_cont;
  logic          r_strobe;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;

  logic          w_svc_req;
  logic          w_svc_wr;
  logic          w_i2c_we;
  logic [AW-1:0] w_ptr_inc;

  // A request level has priority over a simultaneous avail level.
  assign w_svc_req = slave_act && slave_dat_req &&
                     ((r_state == S_ADDR) || (r_state == S_DATA));
  assign w_svc_wr  = slave_act && slave_dat_avail && !slave_dat_req && (r_state == S_DATA);
  assign w_i2c_we  = w_svc_wr && !RO_MASK[r_ptr];
  assign w_ptr_inc = r_ptr + 1'b1;

  assign tx_byte       = r_tx;
  assign sl_cont       = r_cont;
  assign i2c_wr_strobe = r_strobe;
  assign i2c_wr_addr   = r_wr_addr;
  assign i2c_wr_data   = r_wr_data;
  assign reg_ptr       = r_ptr;
  assign loc_rdata     = r_regs[loc_addr];

  // Local write is issued last so it overrides an I2C write to the same register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_i2c_we) r_regs[r_ptr] <= rx_byte;
      if (loc_we)   r_regs[loc_addr] <= loc_wdata;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state   <= S_IDLE;
      r_next    <= S_IDLE;
      r_ptr     <= '0;
      r_tx      <= '0;
      r_cont    <= 1'b0;
      r_strobe  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_cont   <= 1'b0;
      r_strobe <= 1'b0;
      if ((r_state != S_IDLE) && !slave_act) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (slave_act) r_state <= S_ADDR;
          S_ADDR, S_DATA: begin
            if (w_svc_req) begin
              r_tx    <= r_regs[r_ptr];
              r_ptr   <= w_ptr_inc;
              r_cont  <= 1'b1;
              r_next  <= S_DATA;
              r_state <= S_CONT;
            end else if (slave_dat_avail) begin
              r_cont  <= 1'b1;
              r_state <= S_CONT;
              if (r_state == S_ADDR) begin
                r_next <= S_PTR;
              end else begin
                r_next <= S_DATA;
                r_ptr  <= w_ptr_inc;
                if (w_i2c_we) begin
                  r_strobe  <= 1'b1;
                  r_wr_addr <= r_ptr;
                  r_wr_data <= rx_byte;
                end
              end
            end
          end
          S_PTR: begin
            if (slave_dat_avail) begin
              r_ptr   <= rx_byte[AW-1:0];
              r_cont  <= 1'b1;
              r_next  <= S_DATA;
              r_state <= S_CONT;
            end
          end
          S_CONT: if (!slave_dat_avail && !slave_dat_req) r_state <= r_next;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
